// File: rtl/bits_corr_pkg.sv
// Shared widths, mask helper and score/polarity payload for the multi-pattern bit correlator.
package bits_corr_pkg;

   // Largest window length the mask helper and score payload are sized for
   localparam int unsigned MAX_LENGTH = 256;

   // Width needed to count 0..length
   function automatic int unsigned cw_f(input int unsigned length);
      return 32'($clog2(length + 1));
   endfunction

   // Index width for n items, never narrower than one bit
   function automatic int unsigned iw_f(input int unsigned n);
      return (n <= 1) ? 32'd1 : 32'($clog2(n));
   endfunction

   localparam int unsigned MAX_CW = cw_f(MAX_LENGTH);

   // Thermometer mask with bits [n-1:0] set; n >= MAX_LENGTH yields all ones
   function automatic logic [MAX_LENGTH-1:0] mask_f(input int unsigned n);
      logic [MAX_LENGTH-1:0] ones;
      ones = '1;
      return ~(ones << n);
   endfunction

   // Per-correlator best-of-both-polarities result
   typedef struct packed {
      logic              pol;
      logic [MAX_CW-1:0] score;
   } score_pol_t;

endpackage

// File: rtl/bits_popcount.sv
// Two-stage registered popcount: per-slice counts, then slice sum, with valid/length passthrough.
module bits_popcount
   import bits_corr_pkg::*;
#(
   parameter  int unsigned LENGTH = 64,
   parameter  int unsigned SLICE  = 16,
   localparam int unsigned CW     = cw_f(LENGTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [LENGTH-1:0] in_vec,
   input  logic [CW-1:0]     in_len,
   output logic              out_vld,
   output logic [CW-1:0]     out_sum,
   output logic [CW-1:0]     out_len
);

   localparam int unsigned NS = LENGTH / SLICE;
   localparam int unsigned SW = cw_f(SLICE);

   logic [SW-1:0] slice_c [NS];
   logic [SW-1:0] slice_q [NS];
   logic [CW-1:0] len_q;
   logic          vld_q;
   logic [CW-1:0] sum_c;

   // First-level counts, one per slice
   for (genvar s = 0; s < NS; s++) begin : g_slice
      assign slice_c[s] = SW'($countones(in_vec[s*SLICE +: SLICE]));
   end

   // Second-level sum of registered slice counts
   always_comb begin
      sum_c = '0;
      for (int s = 0; s < int'(NS); s++) begin
         sum_c = sum_c + CW'(slice_q[s]);
      end
   end

   // Pipeline registers; data only moves with its valid so results hold between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         len_q   <= '0;
         out_vld <= 1'b0;
         out_sum <= '0;
         out_len <= '0;
         for (int s = 0; s < int'(NS); s++) begin
            slice_q[s] <= '0;
         end
      end else begin
         vld_q   <= in_vld;
         out_vld <= vld_q;
         if (in_vld) begin
            slice_q <= slice_c;
            len_q   <= in_len;
         end
         if (vld_q) begin
            out_sum <= sum_c;
            out_len <= len_q;
         end
      end
   end

endmodule

// File: rtl/bits_correlator_multi.sv
// Sliding-window bit correlator against NUM_CORR programmable patterns with polarity-aware argmax detector and hold-off.
module bits_correlator_multi
   import bits_corr_pkg::*;
#(
   parameter  int unsigned LENGTH   = 64,
   parameter  int unsigned NUM_CORR = 4,
   parameter  int unsigned SLICE    = 16,
   parameter  int unsigned HW       = 16,
   localparam int unsigned CW       = cw_f(LENGTH),
   localparam int unsigned IW       = iw_f(NUM_CORR)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_dat,
   input  logic                   in_vld,
   input  logic                   cfg_we,
   input  logic [IW-1:0]          cfg_idx,
   input  logic [LENGTH-1:0]      cfg_coeff,
   input  logic [CW-1:0]          cfg_len,
   input  logic [CW-1:0]          threshold,
   input  logic [HW-1:0]          holdoff,
   output logic [NUM_CORR*CW-1:0] corr_dat,
   output logic                   corr_vld,
   output logic                   det_vld,
   output logic [IW-1:0]          det_idx,
   output logic [CW-1:0]          det_score,
   output logic                   det_pol
);

   localparam logic [CW-1:0] LEN_MAX = CW'(LENGTH);

   logic [LENGTH-1:0] win;
   logic              win_vld;

   logic [LENGTH-1:0] coeff_q [NUM_CORR];
   logic [CW-1:0]     len_q   [NUM_CORR];
   logic [CW-1:0]     len_clamp;

   logic [LENGTH-1:0] agree_c [NUM_CORR];
   logic [LENGTH-1:0] agree_q [NUM_CORR];
   logic [CW-1:0]     alen_q  [NUM_CORR];
   logic              agree_vld;

   logic [CW-1:0]       cnt     [NUM_CORR];
   logic [CW-1:0]       cnt_len [NUM_CORR];
   logic [NUM_CORR-1:0] cnt_vld;
   logic                s3_vld;

   logic [CW-1:0] dis_c [NUM_CORR];
   score_pol_t    sp    [NUM_CORR];

   logic          found;
   logic [CW-1:0] best_score;
   logic [IW-1:0] best_idx;
   logic          best_pol;
   logic          det_fire;
   logic [HW-1:0] hold_q;

   // Sample window, newest bit at position 0
   always_ff @(posedge clk) begin
      if (rst) begin
         win     <= '0;
         win_vld <= 1'b0;
      end else begin
         win_vld <= in_vld;
         if (in_vld) begin
            win <= {win[LENGTH-2:0], in_dat};
         end
      end
   end

   assign len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

   // Pattern store; indices that match no correlator are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NUM_CORR); k++) begin
            coeff_q[k] <= '0;
            len_q[k]   <= '0;
         end
      end else if (cfg_we) begin
         for (int k = 0; k < int'(NUM_CORR); k++) begin
            if (cfg_idx == IW'(k)) begin
               coeff_q[k] <= cfg_coeff;
               len_q[k]   <= len_clamp;
            end
         end
      end
   end

   // Stage 1 agree vectors restricted to each active length
   always_comb begin
      for (int k = 0; k < int'(NUM_CORR); k++) begin
         agree_c[k] = ~(win ^ coeff_q[k]) & LENGTH'(mask_f(32'(len_q[k])));
      end
   end

   // Stage 1 register, pattern length travels with its agree vector
   always_ff @(posedge clk) begin
      if (rst) begin
         agree_vld <= 1'b0;
         for (int k = 0; k < int'(NUM_CORR); k++) begin
            agree_q[k] <= '0;
            alen_q[k]  <= '0;
         end
      end else begin
         agree_vld <= win_vld;
         if (win_vld) begin
            agree_q <= agree_c;
            alen_q  <= len_q;
         end
      end
   end

   // Stages 2-3: one popcount pipeline per correlator
   for (genvar k = 0; k < NUM_CORR; k++) begin : g_corr
      bits_popcount #(
         .LENGTH (LENGTH),
         .SLICE  (SLICE)
      ) u_popcount (
         .clk     (clk),
         .rst     (rst),
         .in_vld  (agree_vld),
         .in_vec  (agree_q[k]),
         .in_len  (alen_q[k]),
         .out_vld (cnt_vld[k]),
         .out_sum (cnt[k]),
         .out_len (cnt_len[k])
      );
      assign corr_dat[k*CW +: CW] = cnt[k];
   end

   assign s3_vld   = &cnt_vld;
   assign corr_vld = s3_vld;

   // Stage 3 score: better of direct and inverted agreement, ties count as direct
   always_comb begin
      for (int k = 0; k < int'(NUM_CORR); k++) begin
         sp[k]       = '0;
         dis_c[k]    = cnt_len[k] - cnt[k];
         sp[k].pol   = dis_c[k] > cnt[k];
         sp[k].score = MAX_CW'(sp[k].pol ? dis_c[k] : cnt[k]);
      end
   end

   // Argmax over enabled candidates; strict compare keeps the lowest index on ties
   always_comb begin
      found      = 1'b0;
      best_score = '0;
      best_idx   = '0;
      best_pol   = 1'b0;
      for (int k = 0; k < int'(NUM_CORR); k++) begin
         if ((cnt_len[k] != '0) && (CW'(sp[k].score) >= threshold) &&
             (!found || (CW'(sp[k].score) > best_score))) begin
            found      = 1'b1;
            best_score = CW'(sp[k].score);
            best_idx   = IW'(k);
            best_pol   = sp[k].pol;
         end
      end
   end

   assign det_fire = s3_vld && found && (threshold != '0) && (hold_q == '0);

   // Stage 4 detector outputs and hold-off counter, advanced only by valid samples
   always_ff @(posedge clk) begin
      if (rst) begin
         det_vld   <= 1'b0;
         det_idx   <= '0;
         det_score <= '0;
         det_pol   <= 1'b0;
         hold_q    <= '0;
      end else begin
         det_vld <= det_fire;
         if (det_fire) begin
            det_idx   <= best_idx;
            det_score <= best_score;
            det_pol   <= best_pol;
         end
         if (s3_vld) begin
            if (det_fire) begin
               hold_q <= holdoff;
            end else if (hold_q != '0) begin
               hold_q <= hold_q - HW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bits_correlator_multi.sv
// Directed self-checking bench for bits_correlator_multi.
module tb_bits_correlator_multi;

   localparam int unsigned LENGTH   = 64;
   localparam int unsigned NUM_CORR = 4;
   localparam int unsigned SLICE    = 16;
   localparam int unsigned HW       = 16;
   localparam int unsigned CW       = 7;
   localparam int unsigned IW       = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_dat;
   logic                   in_vld;
   logic                   cfg_we;
   logic [IW-1:0]          cfg_idx;
   logic [LENGTH-1:0]      cfg_coeff;
   logic [CW-1:0]          cfg_len;
   logic [CW-1:0]          threshold;
   logic [HW-1:0]          holdoff;
   logic [NUM_CORR*CW-1:0] corr_dat;
   logic                   corr_vld;
   logic                   det_vld;
   logic [IW-1:0]          det_idx;
   logic [CW-1:0]          det_score;
   logic                   det_pol;

   int checks = 0;
   int errors = 0;
   int corr_cnt = 0;
   int det_cnt = 0;
   int det_samp[$];

   localparam logic [LENGTH-1:0] PAT_A = {8{8'hA5}};
   localparam logic [LENGTH-1:0] PAT_Q = 64'h0123_4567_89AB_CDEF;

   always #5 clk = ~clk;

   bits_correlator_multi #(
      .LENGTH   (LENGTH),
      .NUM_CORR (NUM_CORR),
      .SLICE    (SLICE),
      .HW       (HW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_dat    (in_dat),
      .in_vld    (in_vld),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_coeff (cfg_coeff),
      .cfg_len   (cfg_len),
      .threshold (threshold),
      .holdoff   (holdoff),
      .corr_dat  (corr_dat),
      .corr_vld  (corr_vld),
      .det_vld   (det_vld),
      .det_idx   (det_idx),
      .det_score (det_score),
      .det_pol   (det_pol)
   );

   // Strobe monitor: det for sample n arrives one cycle after corr for sample n
   always @(negedge clk) begin
      if (det_vld) begin
         det_cnt = det_cnt + 1;
         det_samp.push_back(corr_cnt - 1);
      end
      if (corr_vld) corr_cnt = corr_cnt + 1;
   end

   function automatic logic [CW-1:0] corr_of(input int k);
      return corr_dat[k*CW +: CW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      corr_cnt = 0;
      det_cnt  = 0;
      det_samp.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_vld = 1'b0; in_dat = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_coeff = '0; cfg_len = '0; threshold = '0; holdoff = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [IW-1:0] idx, input logic [LENGTH-1:0] c, input logic [CW-1:0] l);
      cfg_we = 1'b1; cfg_idx = idx; cfg_coeff = c; cfg_len = l;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      in_dat = b;
      in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      repeat (gap) tick();
   endtask

   // Oldest bit first so that pattern bit 0 ends up aligned with the newest sample
   task automatic send_pattern(input logic [LENGTH-1:0] p);
      for (int i = LENGTH - 1; i >= 0; i--) send_bit(p[i], 0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (corr_dat !== '0) begin errors++; $display("FAIL reset_corr_dat: got %h expected 0", corr_dat); end
      checks++; if (corr_vld !== 1'b0) begin errors++; $display("FAIL reset_corr_vld: got %b expected 0", corr_vld); end
      checks++; if (det_vld !== 1'b0) begin errors++; $display("FAIL reset_det_vld: got %b expected 0", det_vld); end
      checks++; if (det_idx !== '0) begin errors++; $display("FAIL reset_det_idx: got %0d expected 0", det_idx); end
      checks++; if (det_score !== '0) begin errors++; $display("FAIL reset_det_score: got %0d expected 0", det_score); end
      checks++; if (det_pol !== 1'b0) begin errors++; $display("FAIL reset_det_pol: got %b expected 0", det_pol); end
   endtask

   task automatic test_basic_match();
      do_reset();
      cfg_write(2'd0, PAT_A, 7'd64);
      threshold = 7'd60;
      send_pattern(PAT_A);
      repeat (3) tick();
      checks++; if (corr_vld !== 1'b1) begin errors++; $display("FAIL basic_corr_vld_t3: got %b expected 1", corr_vld); end
      checks++; if (corr_of(0) !== 7'd64) begin errors++; $display("FAIL basic_corr0: got %0d expected 64", corr_of(0)); end
      tick();
      checks++; if (det_vld !== 1'b1) begin errors++; $display("FAIL basic_det_vld_t4: got %b expected 1", det_vld); end
      checks++; if (corr_vld !== 1'b0) begin errors++; $display("FAIL basic_corr_vld_t4: got %b expected 0", corr_vld); end
      checks++; if (det_idx !== 2'd0) begin errors++; $display("FAIL basic_det_idx: got %0d expected 0", det_idx); end
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL basic_det_score: got %0d expected 64", det_score); end
      checks++; if (det_pol !== 1'b0) begin errors++; $display("FAIL basic_det_pol: got %b expected 0", det_pol); end
      tick();
      checks++; if (det_vld !== 1'b0) begin errors++; $display("FAIL basic_det_pulse: got %b expected 0", det_vld); end
      checks++; if (corr_of(0) !== 7'd64) begin errors++; $display("FAIL basic_corr_hold: got %0d expected 64", corr_of(0)); end
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL basic_score_hold: got %0d expected 64", det_score); end
   endtask

   task automatic test_inverted();
      send_pattern(~PAT_A);
      repeat (3) tick();
      checks++; if (corr_of(0) !== 7'd0) begin errors++; $display("FAIL inv_corr0: got %0d expected 0", corr_of(0)); end
      tick();
      checks++; if (det_vld !== 1'b1) begin errors++; $display("FAIL inv_det_vld: got %b expected 1", det_vld); end
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL inv_det_score: got %0d expected 64", det_score); end
      checks++; if (det_pol !== 1'b1) begin errors++; $display("FAIL inv_det_pol: got %b expected 1", det_pol); end
   endtask

   task automatic test_len_clamp();
      do_reset();
      cfg_write(2'd1, '0, 7'd100);
      cfg_write(2'd2, 64'h0000_0000_0000_00FF, 7'd8);
      threshold = 7'd0;
      for (int i = 0; i < 56; i++) send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
      repeat (3) tick();
      checks++; if (corr_vld !== 1'b1) begin errors++; $display("FAIL len_corr_vld: got %b expected 1", corr_vld); end
      checks++; if (corr_of(0) !== 7'd0) begin errors++; $display("FAIL len_corr0_disabled: got %0d expected 0", corr_of(0)); end
      checks++; if (corr_of(1) !== 7'd56) begin errors++; $display("FAIL len_corr1: got %0d expected 56", corr_of(1)); end
      checks++; if (corr_of(2) !== 7'd8) begin errors++; $display("FAIL len_corr2_mask: got %0d expected 8", corr_of(2)); end
      threshold = 7'd60;
      for (int i = 0; i < 64; i++) send_bit(1'b1, 0);
      repeat (3) tick();
      checks++; if (corr_of(1) !== 7'd0) begin errors++; $display("FAIL len_corr1_ones: got %0d expected 0", corr_of(1)); end
      checks++; if (corr_of(2) !== 7'd8) begin errors++; $display("FAIL len_corr2_ones: got %0d expected 8", corr_of(2)); end
      tick();
      checks++; if (det_vld !== 1'b1) begin errors++; $display("FAIL len_det_vld: got %b expected 1", det_vld); end
      checks++; if (det_idx !== 2'd1) begin errors++; $display("FAIL len_det_idx: got %0d expected 1", det_idx); end
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL len_clamp_score: got %0d expected 64", det_score); end
      checks++; if (det_pol !== 1'b1) begin errors++; $display("FAIL len_det_pol: got %b expected 1", det_pol); end
   endtask

   task automatic test_argmax_tie();
      do_reset();
      cfg_write(2'd0, PAT_Q, 7'd62);
      cfg_write(2'd1, PAT_Q, 7'd64);
      cfg_write(2'd3, PAT_Q, 7'd64);
      threshold = 7'd60;
      send_pattern(PAT_Q);
      repeat (4) tick();
      checks++; if (det_vld !== 1'b1) begin errors++; $display("FAIL tie_det_vld: got %b expected 1", det_vld); end
      checks++; if (det_idx !== 2'd1) begin errors++; $display("FAIL tie_det_idx: got %0d expected 1", det_idx); end
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL tie_det_score: got %0d expected 64", det_score); end
      checks++; if (det_pol !== 1'b0) begin errors++; $display("FAIL tie_det_pol: got %b expected 0", det_pol); end
   endtask

   // Zeros against an all-zero pattern match on every sample; gap > 0 exercises stalls
   task automatic test_holdoff(input int gap);
      int got;
      do_reset();
      cfg_write(2'd0, '0, 7'd64);
      threshold = 7'd60;
      holdoff   = 16'd5;
      clear_mon();
      for (int i = 0; i < 20; i++) send_bit(1'b0, gap);
      repeat (6) tick();
      checks++; if (corr_cnt != 20) begin errors++; $display("FAIL holdoff_gap%0d_corr_cnt: got %0d expected 20", gap, corr_cnt); end
      checks++; if (det_cnt != 4) begin errors++; $display("FAIL holdoff_gap%0d_det_cnt: got %0d expected 4", gap, det_cnt); end
      for (int i = 0; i < 4; i++) begin
         got = (i < det_samp.size()) ? det_samp[i] : -1;
         checks++; if (got != 6 * i) begin errors++; $display("FAIL holdoff_gap%0d_det%0d_sample: got %0d expected %0d", gap, i, got, 6 * i); end
      end
   endtask

   task automatic test_disable();
      do_reset();
      cfg_write(2'd0, '0, 7'd64);
      threshold = 7'd0;
      clear_mon();
      for (int i = 0; i < 10; i++) send_bit(1'b0, 0);
      repeat (6) tick();
      checks++; if (det_cnt != 0) begin errors++; $display("FAIL disable_det_cnt: got %0d expected 0", det_cnt); end
      checks++; if (corr_cnt != 10) begin errors++; $display("FAIL disable_corr_cnt: got %0d expected 10", corr_cnt); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      cfg_write(2'd2, '0, 7'd64);
      threshold = 7'd60;
      for (int i = 0; i < 10; i++) send_bit(1'b0, 0);
      repeat (6) tick();
      checks++; if (det_score !== 7'd64) begin errors++; $display("FAIL midrst_pre_score: got %0d expected 64", det_score); end
      clear_mon();
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      rst = 1'b1;
      tick();
      checks++; if (corr_dat !== '0) begin errors++; $display("FAIL midrst_corr_dat: got %h expected 0", corr_dat); end
      checks++; if (det_score !== '0) begin errors++; $display("FAIL midrst_det_score: got %0d expected 0", det_score); end
      checks++; if (det_idx !== '0) begin errors++; $display("FAIL midrst_det_idx: got %0d expected 0", det_idx); end
      checks++; if (corr_vld !== 1'b0 || det_vld !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got %b%b expected 00", corr_vld, det_vld); end
      rst = 1'b0;
      repeat (8) tick();
      checks++; if (corr_cnt != 0 || det_cnt != 0) begin errors++; $display("FAIL midrst_no_strobe: got corr=%0d det=%0d expected 0", corr_cnt, det_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic_match();
      test_inverted();
      test_len_clamp();
      test_argmax_tie();
      test_holdoff(0);
      test_holdoff(2);
      test_disable();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
